ecc_secded_pipe: RTL and testbench
==================================

Name: ecc_secded_pipe

Overview:
- Parametrised, pipelined SEC-DED decoder/corrector; the next generation of the team's 32-bit single-error-correcting data-path block.
- Generalised to any data width, with an extended Hamming code that also detects double errors.
- Streaming valid/ready interface, per-word status, saturating error counters, and a per-word check-enable mode.
- Sits between the memory or link read path and the consumer.

Parameters:
- DATA_W, 32, data bits per word (4..120).
- P, 6, Hamming check bits; the smallest P with 2^P >= DATA_W+P+1 (6 for 32); elaboration error otherwise.
- CNT_W, 16, width of each saturating error counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_data  in  DATA_W  received data bits.
- in_chk  in  P+1  [P-1:0] Hamming check bits; [P] overall parity bit.
- in_chk_en  in  1  1 = decode/correct; 0 = bypass (check bits treated as absent).
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  DATA_W  corrected data.
- out_status  out  2  00 clean, 01 data bit corrected, 10 check/parity bit error (data unchanged), 11 uncorrectable.
- out_err_pos  out  $clog2(DATA_W)  index of the corrected data bit; 0 unless status=01.
- cnt_corr  out  CNT_W  count of status 01/10 words.
- cnt_uncorr  out  CNT_W  count of status 11 words.
- cnt_clr  in  1  synchronous clear of both counters.

Behaviour:
- Code layout:
  - Codeword positions are 1..N, N = DATA_W+P.
  - Hamming bit in_chk[i] sits at position 2^i.
  - Data bits fill the non-power-of-two positions in ascending order, in_data[0] at position 3.
- Decode:
  - syn = XOR of the position numbers of all set codeword bits (P bits).
  - par = XOR of all in_data, in_chk[P-1:0] and in_chk[P].
- Classification (chk_en=1):
  - syn=0, par=0: status 00.
  - syn=0, par=1: status 10.
  - syn≠0, par=1, syn a power of two: status 10.
  - syn≠0, par=1, syn a data position <= N: status 01; that data bit is flipped; out_err_pos = its index.
  - syn≠0, par=1, syn > N: status 11.
  - syn≠0, par=0: status 11.
  - On status 11, data passes unmodified.
- chk_en=0: data passes unchanged, status 00, counters untouched.
- Pipeline: two register stages.
  - S1 registers data, syn, par, chk_en.
  - S2 registers corrected data, status and err_pos; S2 drives the out_* ports.
  - Latency 2 cycles from input accept to out_valid with no backpressure; throughput 1 word/cycle.
- Handshake:
  - en2 = !s2_v | out_ready; en1 = !s1_v | en2; in_ready = en1 (combinational from out_ready and state; no combinational in_valid→out path).
  - A transfer occurs when valid & ready are both high.
  - out_* stays stable while out_valid=1 and out_ready=0.
  - Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Counters:
  - Increment when a word with the matching status transfers out (out_valid & out_ready); saturate at 2^CNT_W-1.
  - cnt_clr has priority over a same-cycle increment: the result is 0.
- Reset (async assert, sync release):
  - s1_v = s2_v = 0, out_valid = 0, out_data = 0, out_status = 00, out_err_pos = 0, cnt_* = 0.
  - in_ready = 1 after reset.
  - Reset mid-stream discards all in-flight words; no partial output.
- Non-valid cycles: in_data/in_chk are ignored; stage registers hold when not enabled.

Test Plan:
- Clean and single data-bit error (DATA_W=32):
  - in_data=0x00000000, in_chk=0 → 2 cycles later out_data=0, status 00.
  - in_data=0x00000001, in_chk=0 → out_data=0x00000000, status 01, err_pos=0, cnt_corr=1.
- Check/parity bit errors:
  - in_data=0, in_chk=0x01 → data 0, status 10.
  - in_data=0, in_chk=0x40 → data 0, status 10.
  - cnt_corr increments by 1 for each.
- Double error: in_data=0x00000003, in_chk=0 (syn=6, par=0) → out_data=0x00000003, status 11, cnt_uncorr=1.
- Bypass mode: in_data=0x00000001, in_chk=0, in_chk_en=0 → out_data=0x00000001, status 00, counters unchanged.
- Backpressure:
  - Stream 8 words at back-to-back in_valid with out_ready held 0 → exactly 2 accepted, in_ready=0, out_* stable.
  - Release out_ready → all 8 words emerge in order, no loss or duplication.
- Saturation, clear and reset (CNT_W=4):
  - 20 single-error words → cnt_corr=15.
  - cnt_clr asserted together with a corrected word → 0.
  - rst_n pulsed low with 2 words in flight → out_valid=0 immediately, no stale output after release.

Source files
------------

// File: rtl/ecc_secded_pipe.sv
// Two-stage pipelined extended-Hamming (SEC-DED) decoder/corrector with a
// valid/ready stream, per-word status and saturating error counters.
module ecc_secded_pipe #(
    parameter int DATA_W = 32,
    parameter int P      = 6,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [P:0]                in_chk,
    input  logic                      in_chk_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [1:0]                out_status,
    output logic [$clog2(DATA_W)-1:0] out_err_pos,
    output logic [CNT_W-1:0]          cnt_corr,
    output logic [CNT_W-1:0]          cnt_uncorr,
    input  logic                      cnt_clr
);

    localparam int N     = DATA_W + P;
    localparam int POS_W = $clog2(DATA_W);

    localparam logic [1:0] ST_CLEAN   = 2'b00;
    localparam logic [1:0] ST_CORR    = 2'b01;
    localparam logic [1:0] ST_CHK_ERR = 2'b10;
    localparam logic [1:0] ST_UNCORR  = 2'b11;

    // P must be the smallest check-bit count covering DATA_W+P+1 code states.
    if (DATA_W < 4 || DATA_W > 120 || (1 << P) < N + 1 || (1 << (P - 1)) >= N) begin : g_bad_param
        $error("ecc_secded_pipe: illegal DATA_W/P combination");
    end

    // Codeword position of data bit j: the j-th non-power-of-two position from 3 upward.
    function automatic int data_pos(input int j);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int p = 3; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) res = p;
                cnt++;
            end
        end
        return res;
    endfunction

    logic [P-1:0] pos_tab [DATA_W];

    for (genvar g = 0; g < DATA_W; g++) begin : g_pos
        assign pos_tab[g] = P'(data_pos(g));
    end

    logic en1, en2;
    logic s1_v, s1_par, s1_en;
    logic [DATA_W-1:0] s1_data;
    logic [P-1:0] s1_syn;
    logic [P-1:0] in_syn;
    logic in_par;

    assign en2      = !out_valid || out_ready;
    assign en1      = !s1_v || en2;
    assign in_ready = en1;

    // Check bit i lives at position 2^i, so it only touches syndrome bit i.
    always_comb begin
        in_syn = in_chk[P-1:0];
        for (int j = 0; j < DATA_W; j++) begin
            if (in_data[j]) in_syn = in_syn ^ pos_tab[j];
        end
        in_par = (^in_data) ^ (^in_chk);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_syn  <= '0;
            s1_par  <= 1'b0;
            s1_en   <= 1'b0;
        end else if (en1) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_syn  <= in_syn;
                s1_par  <= in_par;
                s1_en   <= in_chk_en;
            end
        end
    end

    logic [DATA_W-1:0] nxt_data;
    logic [1:0] nxt_status;
    logic [POS_W-1:0] nxt_pos;
    logic syn_pow2;

    assign syn_pow2 = (s1_syn & (s1_syn - P'(1))) == '0;

    always_comb begin
        nxt_data   = s1_data;
        nxt_status = ST_CLEAN;
        nxt_pos    = '0;
        if (s1_en) begin
            if (s1_syn == '0) begin
                nxt_status = s1_par ? ST_CHK_ERR : ST_CLEAN;
            end else if (!s1_par) begin
                nxt_status = ST_UNCORR;
            end else if (syn_pow2) begin
                nxt_status = ST_CHK_ERR;
            end else if (int'(s1_syn) > N) begin
                nxt_status = ST_UNCORR;
            end else begin
                nxt_status = ST_CORR;
                for (int j = 0; j < DATA_W; j++) begin
                    if (pos_tab[j] == s1_syn) begin
                        nxt_data[j] = ~s1_data[j];
                        nxt_pos     = POS_W'(j);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_status  <= ST_CLEAN;
            out_err_pos <= '0;
        end else if (en2) begin
            out_valid <= s1_v;
            if (s1_v) begin
                out_data    <= nxt_data;
                out_status  <= nxt_status;
                out_err_pos <= nxt_pos;
            end
        end
    end

    logic xfer_out;
    assign xfer_out = out_valid && out_ready;

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (cnt_clr) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (xfer_out) begin
            if ((out_status == ST_CORR || out_status == ST_CHK_ERR) && cnt_corr != '1)
                cnt_corr <= cnt_corr + CNT_W'(1);
            if (out_status == ST_UNCORR && cnt_uncorr != '1)
                cnt_uncorr <= cnt_uncorr + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Scoreboard bench for ecc_secded_pipe: a driver feeds a stimulus queue, a
// codeword-level reference model predicts each word, a monitor checks outputs.
module tb_ecc_secded_pipe;

    localparam int DW = 32;
    localparam int PW = 6;
    localparam int CW = 4;
    localparam int NN = DW + PW;

    typedef struct {
        logic [DW-1:0] d;
        logic [PW:0]   c;
        logic          en;
    } stim_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    status;
        logic [4:0]    pos;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [PW:0]   in_chk;
    logic          in_chk_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_status;
    logic [4:0]    out_err_pos;
    logic [CW-1:0] cnt_corr;
    logic [CW-1:0] cnt_uncorr;
    logic          cnt_clr;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    accepted = 0;
    int    m_corr = 0;
    int    m_uncorr = 0;
    bit    rand_ready = 0;
    bit    gap_mode = 0;

    ecc_secded_pipe #(.DATA_W(DW), .P(PW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_chk(in_chk), .in_chk_en(in_chk_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_status(out_status), .out_err_pos(out_err_pos),
        .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    function automatic bit is_pow2(input int p);
        return p > 0 && (p & (p - 1)) == 0;
    endfunction

    // Build the codeword as a bit array over positions 1..N and decode from it.
    function automatic exp_t ref_model(input logic [DW-1:0] d, input logic [PW:0] c, input logic en);
        exp_t r;
        bit cw [0:63];
        int k, syn, par, idx;
        r.data = d;
        r.status = 2'd0;
        r.pos = 5'd0;
        if (!en) return r;
        foreach (cw[p]) cw[p] = 1'b0;
        for (int i = 0; i < PW; i++) cw[1 << i] = c[i];
        k = 0;
        for (int p = 1; p <= NN; p++) begin
            if (!is_pow2(p)) begin
                cw[p] = d[k];
                k++;
            end
        end
        syn = 0;
        par = int'(c[PW]);
        for (int p = 1; p <= NN; p++) begin
            if (cw[p]) begin
                syn ^= p;
                par ^= 1;
            end
        end
        if (syn == 0) r.status = (par != 0) ? 2'd2 : 2'd0;
        else if (par == 0) r.status = 2'd3;
        else if (is_pow2(syn)) r.status = 2'd2;
        else if (syn > NN) r.status = 2'd3;
        else begin
            cw[syn] = !cw[syn];
            k = 0;
            idx = 0;
            for (int p = 1; p <= NN; p++) begin
                if (!is_pow2(p)) begin
                    r.data[k] = cw[p];
                    if (p == syn) idx = k;
                    k++;
                end
            end
            r.status = 2'd1;
            r.pos = 5'(idx);
        end
        return r;
    endfunction

    function automatic logic [PW:0] encode(input logic [DW-1:0] d);
        logic [PW:0] c;
        int k, syn;
        syn = 0;
        k = 0;
        for (int p = 1; k < DW; p++) begin
            if (!is_pow2(p)) begin
                if (d[k]) syn ^= p;
                k++;
            end
        end
        c[PW-1:0] = syn[PW-1:0];
        c[PW] = (^d) ^ (^syn[PW-1:0]);
        return c;
    endfunction

    task automatic makeWord(output logic [DW-1:0] d, output logic [PW:0] c, output logic en);
        logic [DW+PW:0] v;
        int kind, a, b;
        d = $urandom;
        v = {encode(d), d};
        en = 1'b1;
        kind = $urandom_range(0, 9);
        a = $urandom_range(0, DW + PW);
        b = (a + $urandom_range(1, DW + PW)) % (DW + PW + 1);
        if (kind >= 3 && kind <= 7) v[a] = ~v[a];
        if (kind == 6 || kind == 7) v[b] = ~v[b];
        if (kind == 8) v[DW+PW:DW] = 7'($urandom);
        if (kind == 9) begin
            en = 1'b0;
            v[a] = ~v[a];
        end
        d = v[DW-1:0];
        c = v[DW+PW:DW];
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input logic [PW:0] c, input logic en);
        stim_t s;
        s.d = d;
        s.c = c;
        s.en = en;
        stim_q.push_back(s);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
            cycle(1);
            n++;
        end
        checkOutput(name, 64'(stim_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic waitAccepted(input string name, input int target, input int limit);
        int n = 0;
        while (accepted < target && n < limit) begin
            cycle(1);
            n++;
        end
        checkOutput(name, 64'(accepted), 64'(target));
    endtask

    // Driver: hold each word until it is accepted, optionally inserting bubbles.
    initial begin : driver
        bit acc;
        in_valid = 1'b0;
        in_data = '0;
        in_chk = '0;
        in_chk_en = 1'b1;
        forever begin
            @(negedge clk);
            acc = rst_n && in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc && rst_n && stim_q.size() > 0) begin
                exp_q.push_back(ref_model(stim_q[0].d, stim_q[0].c, stim_q[0].en));
                void'(stim_q.pop_front());
                accepted++;
            end
            if (stim_q.size() > 0 && !(gap_mode && $urandom_range(0, 3) == 0)) begin
                in_valid = 1'b1;
                in_data = stim_q[0].d;
                in_chk = stim_q[0].c;
                in_chk_en = stim_q[0].en;
            end else begin
                in_valid = 1'b0;
                in_data = $urandom;
                in_chk = 7'($urandom);
                in_chk_en = 1'($urandom);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: the transfer happens on the next rising edge; counters follow the expected status.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_corr = 0;
            m_uncorr = 0;
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_output: got data=0x%0h status=%0d, expected no output",
                             out_data, out_status);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_status, out_err_pos} !== {e.data, e.status, e.pos}) begin
                        failures++;
                        $display("[TB] FAIL word: got data=0x%0h status=%0d pos=%0d, expected data=0x%0h status=%0d pos=%0d",
                                 out_data, out_status, out_err_pos, e.data, e.status, e.pos);
                    end
                    if (!cnt_clr) begin
                        if ((e.status == 2'd1 || e.status == 2'd2) && m_corr < (1 << CW) - 1) m_corr++;
                        if (e.status == 2'd3 && m_uncorr < (1 << CW) - 1) m_uncorr++;
                    end
                end
            end
            if (cnt_clr) begin
                m_corr = 0;
                m_uncorr = 0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [DW-1:0] d;
        logic [PW:0] c;
        logic en;
        logic [63:0] snap;
        int base, vcount, n;

        rst_n = 1'b0;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        cycle(1);

        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_word", {out_data, out_status, out_err_pos}, 64'd0);
        checkOutput("reset_counters", {cnt_corr, cnt_uncorr}, 64'd0);

        // Clean word, also timing the first result through an empty pipe.
        applyStimulus(32'h0, 7'h00, 1'b1);
        cycle(2);
        checkOutput("latency_early", 64'(out_valid), 64'd0);
        cycle(1);
        checkOutput("latency_two", 64'(out_valid), 64'd1);
        waitIdle("idle_clean", 20);
        checkOutput("cnt_after_clean", {cnt_corr, cnt_uncorr}, 64'd0);

        applyStimulus(32'h1, 7'h00, 1'b1);
        waitIdle("idle_single", 20);
        checkOutput("cnt_corr_single", 64'(cnt_corr), 64'd1);

        applyStimulus(32'h0, 7'h01, 1'b1);
        applyStimulus(32'h0, 7'h40, 1'b1);
        waitIdle("idle_chkerr", 20);
        checkOutput("cnt_corr_chkerr", 64'(cnt_corr), 64'd3);

        applyStimulus(32'h3, 7'h00, 1'b1);
        waitIdle("idle_double", 20);
        checkOutput("cnt_uncorr_double", 64'(cnt_uncorr), 64'd1);

        applyStimulus(32'h1, 7'h00, 1'b0);
        waitIdle("idle_bypass", 20);
        checkOutput("cnt_bypass", {cnt_corr, cnt_uncorr}, {56'd0, 4'd3, 4'd1});

        // Backpressure: only the two stages fill while the consumer stalls.
        out_ready = 1'b0;
        base = accepted;
        for (int i = 0; i < 8; i++) begin
            makeWord(d, c, en);
            applyStimulus(d, c, en);
        end
        cycle(10);
        checkOutput("stall_accepted", 64'(accepted - base), 64'd2);
        checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
        snap = {27'd0, out_data, out_status, out_err_pos};
        cycle(3);
        checkOutput("stall_stable", {27'd0, out_data, out_status, out_err_pos}, snap);
        out_ready = 1'b1;
        waitIdle("idle_backpressure", 60);
        checkOutput("bp_accepted", 64'(accepted - base), 64'd8);
        checkOutput("bp_cnt_corr", 64'(cnt_corr), 64'(m_corr));
        checkOutput("bp_cnt_uncorr", 64'(cnt_uncorr), 64'(m_uncorr));

        cnt_clr = 1'b1;
        cycle(1);
        cnt_clr = 1'b0;
        checkOutput("clear_idle", {cnt_corr, cnt_uncorr}, 64'd0);

        // Saturation with single data-bit errors.
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            c = encode(d);
            n = $urandom_range(0, DW - 1);
            d[n] = ~d[n];
            applyStimulus(d, c, 1'b1);
        end
        waitIdle("idle_saturate", 200);
        checkOutput("cnt_corr_saturated", 64'(cnt_corr), 64'd15);
        checkOutput("cnt_uncorr_after_sat", 64'(cnt_uncorr), 64'd0);

        // Clear in the same cycle as a corrected word leaving.
        out_ready = 1'b0;
        applyStimulus(32'h1, 7'h00, 1'b1);
        n = 0;
        while (!out_valid && n < 10) begin
            cycle(1);
            n++;
        end
        checkOutput("clr_word_ready", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        cycle(1);
        cnt_clr = 1'b0;
        checkOutput("clr_priority", 64'(cnt_corr), 64'd0);
        waitIdle("idle_clr", 20);

        // Randomised traffic with bubbles and random consumer stalls.
        rand_ready = 1;
        gap_mode = 1;
        for (int i = 0; i < 12; i++) begin
            makeWord(d, c, en);
            applyStimulus(d, c, en);
        end
        waitIdle("idle_rand_small", 300);
        rand_ready = 0;
        out_ready = 1'b1;
        cycle(1);
        checkOutput("rand_small_corr", 64'(cnt_corr), 64'(m_corr));
        checkOutput("rand_small_uncorr", 64'(cnt_uncorr), 64'(m_uncorr));

        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            makeWord(d, c, en);
            applyStimulus(d, c, en);
        end
        waitIdle("idle_rand_large", 4000);
        rand_ready = 0;
        gap_mode = 0;
        out_ready = 1'b1;
        cycle(1);
        checkOutput("rand_large_corr", 64'(cnt_corr), 64'(m_corr));
        checkOutput("rand_large_uncorr", 64'(cnt_uncorr), 64'(m_uncorr));

        // Reset with two words in flight.
        out_ready = 1'b0;
        base = accepted;
        applyStimulus(32'h1, 7'h00, 1'b1);
        applyStimulus(32'h3, 7'h00, 1'b1);
        waitAccepted("inflight_accepted", base + 2, 20);
        cycle(1);
        checkOutput("inflight_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        stim_q.delete();
        exp_q.delete();
        #1;
        checkOutput("reset_async_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_async_word", {out_data, out_status, out_err_pos}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1);
            if (out_valid) vcount++;
        end
        checkOutput("no_stale_output", 64'(vcount), 64'd0);
        checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("post_reset_counters", {cnt_corr, cnt_uncorr}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
